// File: rtl/tx_resp_arbiter_if.sv
// UART TX byte handshake between the response arbiter (master) and the
// synchronised transmitter (slave): level-held VALID, byte taken while busy is high.
interface tx_resp_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  UART_TX_VALID;
    logic                  UART_TX_busy;

    modport master (
        output P_DATA,
        output UART_TX_VALID,
        input  UART_TX_busy
    );

    modport slave (
        input  P_DATA,
        input  UART_TX_VALID,
        output UART_TX_busy
    );
endinterface

// File: rtl/tx_resp_arbiter.sv
// Response arbiter: one-entry holding registers for rf/alu/err results, fixed
// priority err > rf > alu, serialised into UART bytes (ALU low byte first).
module tx_resp_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     rf_data,
    input  logic                      rf_vld,
    input  logic [2*DATA_WIDTH-1:0]   alu_data,
    input  logic                      alu_vld,
    input  logic [DATA_WIDTH-1:0]     err_code,
    input  logic                      err_vld,
    tx_resp_arbiter_if.master         tx,
    output logic [2:0]                drop,
    output logic                      idle
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE
    } state_e;

    // Values double as bit positions in the pending/drop vectors.
    typedef enum logic [1:0] {
        SRC_RF  = 2'd0,
        SRC_ALU = 2'd1,
        SRC_ERR = 2'd2
    } src_e;

    state_e                  state_q, state_d;
    src_e                    grant_q, grant_d;
    logic                    byte_idx_q, byte_idx_d;
    logic [2:0]              pend_q, pend_d;
    logic [2:0]              drop_q, drop_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   rf_hold_q, rf_hold_d;
    logic [2*DATA_WIDTH-1:0] alu_hold_q, alu_hold_d;
    logic [DATA_WIDTH-1:0]   err_hold_q, err_hold_d;

    logic [2:0] stb;
    logic [2:0] release_v;
    logic [2:0] cap;

    assign stb = {err_vld, alu_vld, rf_vld};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        grant_d    = grant_q;
        byte_idx_d = byte_idx_q;
        p_data_d   = p_data_q;
        valid_d    = valid_q;
        release_v  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if ((pend_q != '0) && !tx.UART_TX_busy) begin
                    if (pend_q[SRC_ERR]) begin
                        grant_d  = SRC_ERR;
                        p_data_d = err_hold_q;
                    end else if (pend_q[SRC_RF]) begin
                        grant_d  = SRC_RF;
                        p_data_d = rf_hold_q;
                    end else begin
                        grant_d  = SRC_ALU;
                        p_data_d = alu_hold_q[DATA_WIDTH-1:0];
                    end
                    byte_idx_d = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx.UART_TX_busy) begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                    // The source is freed only once its final byte is taken.
                    if ((grant_q != SRC_ALU) || byte_idx_q) begin
                        release_v[0] = (grant_q == SRC_RF);
                        release_v[1] = (grant_q == SRC_ALU);
                        release_v[2] = (grant_q == SRC_ERR);
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx.UART_TX_busy) begin
                    if ((grant_q == SRC_ALU) && !byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        p_data_d   = alu_hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
                        valid_d    = 1'b1;
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A release on the same edge frees the slot, so the new strobe is taken rather than dropped.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cap[i]    = stb[i] && (!pend_q[i] || release_v[i]);
            drop_d[i] = stb[i] && pend_q[i] && !release_v[i];
            pend_d[i] = cap[i] || (pend_q[i] && !release_v[i]);
        end
        rf_hold_d  = cap[SRC_RF]  ? rf_data  : rf_hold_q;
        alu_hold_d = cap[SRC_ALU] ? alu_data : alu_hold_q;
        err_hold_d = cap[SRC_ERR] ? err_code : err_hold_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= SRC_RF;
            byte_idx_q <= 1'b0;
            pend_q     <= '0;
            drop_q     <= '0;
            p_data_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            byte_idx_q <= byte_idx_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            p_data_q   <= p_data_d;
            valid_q    <= valid_d;
        end
    end

    // NOTE: holding registers are not reset; the pending flags alone say whether they hold anything.
    always_ff @(posedge clk) begin
        rf_hold_q  <= rf_hold_d;
        alu_hold_q <= alu_hold_d;
        err_hold_q <= err_hold_d;
    end

    assign tx.P_DATA        = p_data_q;
    assign tx.UART_TX_VALID = valid_q;
    assign drop             = drop_q;
    assign idle             = (state_q == ST_IDLE) && (pend_q == '0);

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Bench for tx_resp_arbiter: directed table, multi-cycle corner sequences and a
// randomized run, all compared each cycle against a byte-queue reference model.
module tb_tx_resp_arbiter;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rf_data, err_code;
    logic [15:0] alu_data;
    logic       rf_vld, alu_vld, err_vld;
    logic [2:0] drop;
    logic       idle;

    tx_resp_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    tx_resp_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rf_data  (rf_data),
        .rf_vld   (rf_vld),
        .alu_data (alu_data),
        .alu_vld  (alu_vld),
        .err_code (err_code),
        .err_vld  (err_vld),
        .tx       (bus),
        .drop     (drop),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // UART transmitter model: raises busy u_delay cycles after VALID, holds it u_len cycles.
    bit u_busy = 1'b0;
    bit force_busy = 1'b0;
    bit u_rand = 1'b0;
    int u_delay = 2, u_len = 10, u_dcnt = 0, u_cnt = 0;

    // Reference model: pending flags, held data and a queue of bytes still owed by the grant.
    logic [2:0]  m_pend = '0;
    logic [15:0] m_data [3];
    logic [7:0]  m_job [$];
    int          m_src = 0;
    bit          m_pres = 1'b0, m_wait = 1'b0;
    logic        m_valid = 1'b0;
    logic [7:0]  m_pdata = '0;
    logic [2:0]  m_drop = '0;

    logic [7:0] acc_q [$];
    logic [2:0] drop_seen;

    task automatic model_step();
        logic [2:0]  stb, rel;
        logic [15:0] din [3];
        logic [7:0]  tmp;
        stb    = {err_vld, alu_vld, rf_vld};
        din[0] = {8'h00, rf_data};
        din[1] = alu_data;
        din[2] = {8'h00, err_code};
        rel    = '0;
        m_drop = '0;
        if (!rst) begin
            m_pend = '0; m_job.delete(); m_pres = 0; m_wait = 0; m_valid = 0; m_pdata = '0;
            return;
        end
        if (m_pres) begin
            if (bus.UART_TX_busy) begin
                tmp = m_job.pop_front();
                m_pres = 0; m_wait = 1; m_valid = 0;
                if (m_job.size() == 0) rel[m_src] = 1'b1;
            end
        end else if (m_wait) begin
            if (!bus.UART_TX_busy) begin
                m_wait = 0;
                if (m_job.size() > 0) begin m_pres = 1; m_valid = 1; m_pdata = m_job[0]; end
            end
        end else if (!bus.UART_TX_busy && m_pend != '0) begin
            m_src = m_pend[2] ? 2 : (m_pend[0] ? 0 : 1);
            m_job.push_back(m_data[m_src][7:0]);
            if (m_src == 1) m_job.push_back(m_data[1][15:8]);
            m_pres = 1; m_valid = 1; m_pdata = m_job[0];
        end
        for (int s = 0; s < 3; s++) begin
            if (stb[s]) begin
                if (!m_pend[s] || rel[s]) begin m_data[s] = din[s]; m_pend[s] = 1'b1; end
                else m_drop[s] = 1'b1;
            end else if (rel[s]) begin
                m_pend[s] = 1'b0;
            end
        end
    endtask

    task automatic uart_step();
        if (!rst) begin
            u_busy = 0; u_dcnt = 0; u_cnt = 0;
        end else if (u_busy) begin
            u_cnt--;
            if (u_cnt <= 0) u_busy = 0;
        end else if (bus.UART_TX_VALID) begin
            if (u_dcnt >= u_delay) begin
                u_busy = 1; u_cnt = u_len; u_dcnt = 0;
                if (u_rand) begin u_delay = $urandom_range(0, 3); u_len = $urandom_range(1, 4); end
            end else begin
                u_dcnt++;
            end
        end
        bus.UART_TX_busy = u_busy | force_busy;
    endtask

    // One clock: log any byte accepted at this edge, advance model, compare, clear strobes.
    task automatic tick();
        if (rst && bus.UART_TX_VALID && bus.UART_TX_busy) acc_q.push_back(bus.P_DATA);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("valid", bus.UART_TX_VALID, m_valid);
        check("p_data", bus.P_DATA, m_pdata);
        check("drop", drop, m_drop);
        check("idle", idle, (!m_pres && !m_wait && m_pend == '0));
        drop_seen = drop_seen | drop;
        rf_vld = 0; alu_vld = 0; err_vld = 0;
        uart_step();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        bit done;
        n = 0;
        do begin
            tick();
            n++;
            done = idle && !bus.UART_TX_VALID && !bus.UART_TX_busy;
        end while (!done && n < max_cyc);
        check("drain_timeout", done, 1'b1);
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!bus.UART_TX_VALID && n < max_cyc) begin tick(); n++; end
        check(name, bus.UART_TX_VALID, 1'b1);
    endtask

    task automatic check_bytes(input string name, input int n, input logic [0:3][7:0] exp);
        check({name, "_count"}, acc_q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < acc_q.size()) check({name, "_byte"}, acc_q[i], exp[i]);
    endtask

    task automatic start_scenario();
        acc_q.delete();
        drop_seen = '0;
    endtask

    typedef struct packed {
        logic            rv;
        logic [7:0]      rd;
        logic            av;
        logic [15:0]     ad;
        logic            ev;
        logic [7:0]      ed;
        int              n;
        logic [0:3][7:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rv:1'b1, rd:8'hA5, av:1'b0, ad:16'h0000, ev:1'b0, ed:8'h00, n:1, exp:{8'hA5, 24'h0}};
        vecs[1] = '{rv:1'b0, rd:8'h00, av:1'b1, ad:16'h1234, ev:1'b0, ed:8'h00, n:2, exp:{8'h34, 8'h12, 16'h0}};
        vecs[2] = '{rv:1'b0, rd:8'h00, av:1'b0, ad:16'h0000, ev:1'b1, ed:8'hC3, n:1, exp:{8'hC3, 24'h0}};
        vecs[3] = '{rv:1'b1, rd:8'h55, av:1'b1, ad:16'hBEEF, ev:1'b1, ed:8'hE1, n:4, exp:{8'hE1, 8'h55, 8'hEF, 8'hBE}};
        vecs[4] = '{rv:1'b1, rd:8'h5A, av:1'b1, ad:16'h0F0E, ev:1'b0, ed:8'h00, n:3, exp:{8'h5A, 8'h0E, 8'h0F, 8'h00}};
        vecs[5] = '{rv:1'b0, rd:8'h00, av:1'b1, ad:16'h7788, ev:1'b1, ed:8'h81, n:3, exp:{8'h81, 8'h88, 8'h77, 8'h00}};

        rst = 0; rf_vld = 0; alu_vld = 0; err_vld = 0;
        rf_data = '0; alu_data = '0; err_code = '0;
        bus.UART_TX_busy = 0;
        drop_seen = '0;
        @(negedge clk);
        tick();
        tick();
        check("rst_p_data", bus.P_DATA, 8'h00);
        check("rst_valid", bus.UART_TX_VALID, 1'b0);
        check("rst_drop", drop, 3'b000);
        check("rst_idle", idle, 1'b1);
        rst = 1;
        tick();

        // Latency: pending after strobe edge, VALID with data one edge later.
        start_scenario();
        rf_vld = 1; rf_data = 8'hA5;
        tick();
        check("lat_valid_k", bus.UART_TX_VALID, 1'b0);
        check("lat_idle_k", idle, 1'b0);
        tick();
        check("lat_valid_k1", bus.UART_TX_VALID, 1'b1);
        check("lat_data_k1", bus.P_DATA, 8'hA5);
        run_until_idle(60);
        check_bytes("lat", 1, {8'hA5, 24'h0});

        // Single-cycle strobe combinations and their byte order.
        u_delay = 1; u_len = 3;
        for (int v = 0; v < 6; v++) begin
            start_scenario();
            rf_vld = vecs[v].rv; rf_data = vecs[v].rd;
            alu_vld = vecs[v].av; alu_data = vecs[v].ad;
            err_vld = vecs[v].ev; err_code = vecs[v].ed;
            tick();
            run_until_idle(100);
            check_bytes($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp);
            check($sformatf("vec%0d_nodrop", v), drop_seen, 3'b000);
        end

        // err arriving while the ALU low byte is on the bus waits for the high byte.
        start_scenario();
        alu_vld = 1; alu_data = 16'h1234;
        tick();
        wait_valid("alu_err_valid", 10);
        err_vld = 1; err_code = 8'h07;
        tick();
        run_until_idle(100);
        check_bytes("alu_err", 3, {8'h34, 8'h12, 8'h07, 8'h00});

        // Second strobe while pending is dropped with a one-cycle pulse.
        start_scenario();
        rf_vld = 1; rf_data = 8'h11;
        tick();
        rf_vld = 1; rf_data = 8'h22;
        tick();
        check("drop_pulse", drop, 3'b001);
        tick();
        check("drop_clear", drop, 3'b000);
        run_until_idle(100);
        check_bytes("drop", 1, {8'h11, 24'h0});

        // Strobe on the edge that accepts the previous rf byte is captured, not dropped.
        start_scenario();
        rf_vld = 1; rf_data = 8'h11;
        tick();
        begin
            int n;
            n = 0;
            while (!(bus.UART_TX_VALID && bus.UART_TX_busy) && n < 20) begin tick(); n++; end
            check("rel_accept_seen", bus.UART_TX_VALID && bus.UART_TX_busy, 1'b1);
        end
        rf_vld = 1; rf_data = 8'h66;
        tick();
        check("rel_drop", drop, 3'b000);
        check("rel_pending", idle, 1'b0);
        run_until_idle(100);
        check_bytes("rel", 2, {8'h11, 8'h66, 16'h0});
        check("rel_nodrop", drop_seen, 3'b000);

        // Busy high in IDLE blocks the grant indefinitely.
        start_scenario();
        force_busy = 1; bus.UART_TX_busy = 1;
        rf_vld = 1; rf_data = 8'h3C;
        repeat (6) tick();
        check("blk_valid", bus.UART_TX_VALID, 1'b0);
        check("blk_idle", idle, 1'b0);
        force_busy = 0; bus.UART_TX_busy = u_busy;
        run_until_idle(100);
        check_bytes("blk", 1, {8'h3C, 24'h0});

        // Reset while the ALU high byte is presented aborts the transfer.
        start_scenario();
        alu_vld = 1; alu_data = 16'hBEEF;
        tick();
        begin
            int n;
            n = 0;
            while (!(acc_q.size() == 1 && bus.UART_TX_VALID) && n < 40) begin tick(); n++; end
            check("abort_hi_presented", bus.UART_TX_VALID, 1'b1);
            check("abort_hi_data", bus.P_DATA, 8'hBE);
        end
        rst = 0;
        tick();
        check("abort_valid", bus.UART_TX_VALID, 1'b0);
        check("abort_idle", idle, 1'b1);
        rst = 1;
        repeat (20) begin
            tick();
            check("abort_quiet", bus.UART_TX_VALID, 1'b0);
        end
        check_bytes("abort", 1, {8'hEF, 24'h0});

        // Randomized traffic, random UART timing and occasional resets.
        u_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            rf_vld  = ($urandom_range(0, 5) == 0);
            alu_vld = ($urandom_range(0, 5) == 0);
            err_vld = ($urandom_range(0, 7) == 0);
            rf_data = 8'($urandom);
            alu_data = 16'($urandom);
            err_code = 8'($urandom);
            rst = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst = 1;
        run_until_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_resp_arbiter.md
# tx_resp_arbiter

Response arbiter and sequencer in front of the UART transmitter. It accepts single-cycle result strobes from three requesters: register-file read data, 16-bit ALU results and controller error codes. Each strobe is held in a one-entry holding register, and a fixed-priority scheduler serialises the results into bytes for the UART TX over a valid/busy handshake. It sits in the system-clock domain between the command controller / ALU / register file and the synchronised UART TX interface.

## Interface
Parameters:
- DATA_WIDTH, 8: UART byte width; ALU result width is 2*DATA_WIDTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- rf_data  in  8  register-file read data.
- rf_vld  in  1  single-cycle strobe qualifying rf_data.
- alu_data  in  16  ALU result.
- alu_vld  in  1  single-cycle strobe qualifying alu_data.
- err_code  in  8  error/status code from the command controller.
- err_vld  in  1  single-cycle strobe qualifying err_code.
- UART_TX_busy  in  1  UART TX busy, already synchronised into the clk domain.
- P_DATA  out  8  byte presented to UART TX.
- UART_TX_VALID  out  1  P_DATA valid; level-held until accepted.
- drop  out  3  one-cycle overflow pulses: [0] rf, [1] alu, [2] err.
- idle  out  1  high when the FSM is in IDLE and no source is pending.

## Operation
- Each source has a holding register and a pending flag.
  - A strobe with pending=0 captures the data and sets pending.
  - A strobe with pending=1 discards the new data, keeps the old data, and pulses the matching drop bit.
- Same-cycle strobe and release of the same source: the new data is captured, pending stays 1, and no drop pulse is generated.
- Priority: err > rf > alu. Arbitration happens only in IDLE. The granted source is locked until all of its bytes are accepted.
- ALU results are sent as two bytes: low byte [7:0] first, then [15:8]. An err arriving between the two bytes waits.
- FSM states:
  - IDLE: if any source is pending and UART_TX_busy=0, load P_DATA from the winner's byte 0, set UART_TX_VALID=1, and go to SEND.
  - SEND: hold P_DATA and VALID. A byte is accepted on an edge where UART_TX_busy=1.
    - On acceptance: VALID=0, go to WAIT_DONE.
    - If the accepted byte is the source's last byte, clear that source's pending flag on the same edge.
  - WAIT_DONE: wait for UART_TX_busy=0.
    - If the grant is ALU and the low byte was just sent: load the high byte, VALID=1, go to SEND.
    - Otherwise go to IDLE.
- P_DATA holds its last value when VALID=0. There is no combinational path from inputs to outputs.

## Timing
- Reset (rst=0 at an edge): P_DATA=0, UART_TX_VALID=0, drop=0, idle=1, all pending flags cleared, FSM in IDLE, byte index 0.
- Reset mid-transfer aborts the transfer. VALID is low after that edge, and the held data is lost.
- Latency: a strobe sampled at edge k (FSM in IDLE, busy low) gives pending=1 after edge k; VALID=1 and P_DATA valid after edge k+1.
- drop pulses exactly one cycle, after the edge that sampled the rejected strobe.
- Minimum gap:
  - Busy falling seen at edge m gives IDLE after m; the next VALID comes after m+1.
  - The ALU high byte needs no IDLE cycle: VALID comes after edge m.
- Busy high while in IDLE blocks grant. Pending sources keep waiting; there is no timeout.
- Simultaneous strobes on all three sources in one cycle: all are captured. Send order is err, rf, alu-low, alu-high.

## Test plan
- rf_vld with rf_data=0xA5, busy model asserts 2 cycles after VALID for 10 cycles -> VALID high 2 edges after the strobe, P_DATA=0xA5, VALID drops the edge busy is seen, idle returns high.
- alu_vld with 0x1234 -> two transfers, P_DATA=0x34 then 0x12; an err_vld with 0x07 injected during the low byte is sent third.
- err 0xE1, rf 0x55 and alu 0xBEEF strobed in the same cycle -> byte order E1, 55, EF, BE; drop stays 0.
- Second rf_vld (0x22) while the first (0x11) is pending -> drop[0] pulses one cycle, 0x11 is sent, 0x22 never appears.
- rf_vld coincident with the edge accepting the previous rf byte -> new byte captured and sent next, drop[0]=0.
- rst low while in SEND with alu high byte pending -> VALID=0, idle=1 after one edge; no further bytes after rst releases.
